piezo_tone_scheduler: RTL and testbench
=======================================

// Module: piezo_tone_scheduler
// PURPOSE
//  Shares the single board piezo between up to 3 requesters (alarm, key beep, melody
//  player). Arbitrates by fixed priority, plays one note for a requested duration,
//  then inserts a silent gap. Sits between the main controller's event logic and the
//  piezo pin, replacing direct piezo drive.
// PARAMETERS
//  FRQ        1_000_000  system clock frequency in Hz
//  TICK_DIV   FRQ/100    clocks per duration tick (10 ms at default)
//  GAP_TICKS  1          silent ticks between consecutive notes (>=1)
// PORTS
//  clk        in   1   system clock, all logic on rising edge
//  rst        in   1   asynchronous reset, active-high
//  req        in   3   request per requester; req[2] highest priority, held until ack
//  note_in    in   12  note code per requester, [4*i+3:4*i] for requester i
//  dur_in     in   24  duration in ticks per requester, [8*i+7:8*i]
//  ack        out  3   one-cycle grant pulse; note/dur sampled on that cycle
//  done       out  3   one-cycle pulse when the granted note's duration expires
//  busy       out  1   high in PLAY and GAP
//  owner      out  2   index of current owner; 2'd3 when idle
//  piezo      out  1   square-wave output to piezo pin
// BEHAVIOUR
//  Reset: state IDLE; ack=0, done=0, busy=0, owner=3, piezo=0; all counters 0.
//   Reset mid-note aborts immediately; no done pulse is issued.
//  States: IDLE -> PLAY -> GAP -> IDLE.
//  IDLE: if req!=0, grant i = highest set bit. Next edge: ack[i]=1 for 1 cycle, latch
//   note_in[i], dur_in[i] (0 treated as 1), owner=i, busy=1, enter PLAY. Latency
//   req->ack = 1 clock.
//  PLAY: tick prescaler restarts at grant; counts 0..TICK_DIV-1. Tick counter counts
//   elapsed ticks; when it reaches latched dur: done[owner]=1 for 1 cycle, piezo=0,
//   enter GAP. PLAY length = dur*TICK_DIV clocks exactly.
//  GAP: piezo=0, busy=1, owner unchanged; after GAP_TICKS ticks -> IDLE, busy=0,
//   owner=3. New grants possible from the first IDLE cycle.
//  No preemption: requests arriving in PLAY/GAP are not acked; requester keeps req
//   high and is arbitrated on return to IDLE. Dropping req before ack withdraws it.
//  Tone: half-period table (localparams, HALF = FRQ/(2*f), integer truncation):
//   1 C4 262 Hz, 2 D4 294, 3 E4 330, 4 F4 349, 5 G4 392, 6 A4 440, 7 B4 494, 8 C5 523.
//   Codes 0 and 9..15 are rests: piezo held 0 for full duration, done still pulses.
//  Piezo starts 0 at grant; toggles every HALF clocks while in PLAY. Half-period
//   counter width sized from C4 at FRQ ($clog2). Output registered, no glitches.
//  ack and done never both asserted on the same cycle for one requester.
//  Simultaneous req bits: only the highest is acked; others remain pending.
// TESTING
//  1 Assert rst mid-run -> next cycle piezo=0, busy=0, owner=3, ack=done=0.
//  2 req=001, note=6, dur=3 (FRQ=1e6) -> ack[0] 1 clk later; piezo period 2272 clks
//    (HALF=1136); done[0] 30000 clks after ack; busy drops 10000 clks after done.
//  3 req=101 same cycle -> ack[2] only; req[0] held -> ack[0] first IDLE cycle after
//    requester 2's gap ends.
//  4 note=0, dur=2 -> piezo stays 0 for 20000 clks; done pulses; gap follows.
//  5 dur=0 -> behaves as dur=1: done 10000 clks after ack.
//  6 rst pulsed 5000 clks into PLAY -> no done pulse; fresh req acked normally after.

Source files
------------

// File: rtl/piezo_tone_scheduler.sv
// Fixed-priority scheduler sharing one piezo between three requesters:
// grant, play one timed note as a square wave, then a silent gap.
module piezo_tone_scheduler #(
  parameter int FRQ       = 1_000_000,
  parameter int TICK_DIV  = FRQ / 100,
  parameter int GAP_TICKS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [11:0] note_in,
  input  logic [23:0] dur_in,
  output logic [2:0]  ack,
  output logic [2:0]  done,
  output logic        busy,
  output logic [1:0]  owner,
  output logic        piezo
);

  localparam int HALF_C4 = FRQ / (2 * 262);
  localparam int HALF_D4 = FRQ / (2 * 294);
  localparam int HALF_E4 = FRQ / (2 * 330);
  localparam int HALF_F4 = FRQ / (2 * 349);
  localparam int HALF_G4 = FRQ / (2 * 392);
  localparam int HALF_A4 = FRQ / (2 * 440);
  localparam int HALF_B4 = FRQ / (2 * 494);
  localparam int HALF_C5 = FRQ / (2 * 523);

  localparam int HW = $clog2(HALF_C4 + 1);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int TW = (GW > 8) ? GW : 8;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] dur_q, dur_d;
  logic [HW-1:0] half_q, half_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          piezo_q, piezo_d;
  logic [2:0]    ack_q, ack_d;
  logic [2:0]    done_q, done_d;
  logic [1:0]    owner_q, owner_d;

  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] gnt_note;
  logic [7:0] gnt_dur;
  logic       tick;
  logic       play_end;
  logic       gap_end;

  // Rest codes map to a zero half-period, which keeps the piezo silent.
  function automatic logic [HW-1:0] half_lut(input logic [3:0] code);
    case (code)
      4'd1:    half_lut = HW'(HALF_C4);
      4'd2:    half_lut = HW'(HALF_D4);
      4'd3:    half_lut = HW'(HALF_E4);
      4'd4:    half_lut = HW'(HALF_F4);
      4'd5:    half_lut = HW'(HALF_G4);
      4'd6:    half_lut = HW'(HALF_A4);
      4'd7:    half_lut = HW'(HALF_B4);
      4'd8:    half_lut = HW'(HALF_C5);
      default: half_lut = '0;
    endcase
  endfunction

  assign gnt_valid = |req;
  assign gnt_idx   = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);
  assign gnt_note  = note_in[4*gnt_idx +: 4];
  assign gnt_dur   = dur_in[8*gnt_idx +: 8];

  assign tick     = (presc_q == PRESC_LAST);
  assign play_end = (state_q == PLAY) && tick && (tick_q == dur_q - TW'(1));
  assign gap_end  = (state_q == GAP) && tick && (tick_q == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= '0;
      dur_q   <= '0;
      half_q  <= '0;
      hcnt_q  <= '0;
      piezo_q <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
      owner_q <= 2'd3;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      dur_q   <= dur_d;
      half_q  <= half_d;
      hcnt_q  <= hcnt_d;
      piezo_q <= piezo_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = PLAY;
      PLAY:    if (play_end)  state_d = GAP;
      GAP:     if (gap_end)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_d = presc_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    half_d  = half_q;
    hcnt_d  = hcnt_q;
    piezo_d = piezo_q;
    ack_d   = '0;
    done_d  = '0;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        tick_d  = '0;
        hcnt_d  = '0;
        piezo_d = 1'b0;
        if (gnt_valid) begin
          ack_d   = 3'b001 << gnt_idx;
          owner_d = gnt_idx;
          half_d  = half_lut(gnt_note);
          dur_d   = (gnt_dur == 8'd0) ? TW'(1) : TW'(gnt_dur);
        end
      end
      PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        tick_d  = tick ? tick_q + TW'(1) : tick_q;
        if (half_q != '0) begin
          if (hcnt_q == half_q - HW'(1)) begin
            hcnt_d  = '0;
            piezo_d = ~piezo_q;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        if (play_end) begin
          done_d  = 3'b001 << owner_q;
          piezo_d = 1'b0;
          presc_d = '0;
          tick_d  = '0;
          hcnt_d  = '0;
        end
      end
      GAP: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        tick_d  = tick ? tick_q + TW'(1) : tick_q;
        piezo_d = 1'b0;
        if (gap_end) owner_d = 2'd3;
      end
      default: begin
        piezo_d = 1'b0;
        owner_d = 2'd3;
      end
    endcase
  end

  assign ack   = ack_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);
  assign owner = owner_q;
  assign piezo = piezo_q;

endmodule

// File: tb/tb_piezo_tone_scheduler.sv
// Bench for piezo_tone_scheduler at a scaled clock rate: directed vector
// table, reset/withdraw sequences and random transactions against a timing model.
module tb_piezo_tone_scheduler;

  localparam int FQ = 20000;
  localparam int TD = 50;
  localparam int GT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] note_in;
  logic [23:0] dur_in;
  logic [2:0]  ack;
  logic [2:0]  done;
  logic        busy;
  logic [1:0]  owner;
  logic        piezo;

  int n_checks = 0;
  int n_err    = 0;

  piezo_tone_scheduler #(.FRQ(FQ), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk(clk), .rst(rst), .req(req), .note_in(note_in), .dur_in(dur_in),
    .ack(ack), .done(done), .busy(busy), .owner(owner), .piezo(piezo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [11:0] note;
    logic [23:0] dur;
    int          g;
    int          half;
    int          play;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_half(input int code);
    int f;
    case (code)
      1: f = 262;
      2: f = 294;
      3: f = 330;
      4: f = 349;
      5: f = 392;
      6: f = 440;
      7: f = 494;
      8: f = 523;
      default: f = 0;
    endcase
    return (f == 0) ? 0 : FQ / (2 * f);
  endfunction

  // Piezo level k cycles after the ack edge: flips every 'half' clocks from 0.
  function automatic logic model_piezo(input int half, input int k);
    if (half == 0) return 1'b0;
    return ((k / half) % 2) == 1;
  endfunction

  // Called in an IDLE cycle; returns at the first IDLE cycle after the gap.
  task automatic do_txn(input logic [2:0] r, input logic [11:0] n, input logic [23:0] d,
                        input int g, input int half, input int play);
    logic [2:0] m;
    int bad_play;
    int bad_gap;
    m = 3'b001 << g;
    req = r;
    note_in = n;
    dur_in = d;
    step();
    chk("ack_grant", {29'd0, ack}, {29'd0, m});
    chk("owner_grant", {30'd0, owner}, g);
    chk("busy_grant", {31'd0, busy}, 1);
    req = req & ~m;
    bad_play = 0;
    for (int k = 0; k < play; k++) begin
      if (piezo !== model_piezo(half, k)) bad_play++;
      if (k > 0 && ack !== 3'b000) bad_play++;
      if (done !== 3'b000 || busy !== 1'b1) bad_play++;
      step();
    end
    chk("play_wave", bad_play, 0);
    chk("done_pulse", {29'd0, done}, {29'd0, m});
    bad_gap = 0;
    for (int j = 0; j < GT * TD; j++) begin
      if (busy !== 1'b1 || owner !== g[1:0] || piezo !== 1'b0 || ack !== 3'b000) bad_gap++;
      if (j > 0 && done !== 3'b000) bad_gap++;
      step();
    end
    chk("gap_hold", bad_gap, 0);
    chk("idle_state", {29'd0, busy, owner}, {29'd0, 1'b0, 2'd3});
    $display("txn req=%b note=%h dur=%h owner=%0d half=%0d play=%0d", r, n, d, g, half, play);
  endtask

  initial begin
    vecs[0] = '{req: 3'b001, note: 12'h006, dur: 24'h000003, g: 0, half: 22, play: 150};
    vecs[1] = '{req: 3'b101, note: 12'h801, dur: 24'h020001, g: 2, half: 19, play: 100};
    vecs[2] = '{req: 3'b001, note: 12'h001, dur: 24'h000001, g: 0, half: 38, play: 50};
    vecs[3] = '{req: 3'b010, note: 12'h000, dur: 24'h000200, g: 1, half: 0,  play: 100};
    vecs[4] = '{req: 3'b100, note: 12'h300, dur: 24'h000000, g: 2, half: 30, play: 50};
    vecs[5] = '{req: 3'b010, note: 12'h0C0, dur: 24'h000100, g: 1, half: 0,  play: 50};
    vecs[6] = '{req: 3'b011, note: 12'h074, dur: 24'h000201, g: 1, half: 20, play: 100};
    vecs[7] = '{req: 3'b001, note: 12'h004, dur: 24'h000001, g: 0, half: 28, play: 50};
    vecs[8] = '{req: 3'b100, note: 12'h200, dur: 24'h010000, g: 2, half: 34, play: 50};
    vecs[9] = '{req: 3'b010, note: 12'h050, dur: 24'h000100, g: 1, half: 25, play: 50};

    rst = 1'b1;
    req = '0;
    note_in = '0;
    dur_in = '0;
    repeat (3) step();
    chk("reset_out", {24'd0, ack, done, busy, owner, piezo}, {24'd0, 3'b0, 3'b0, 1'b0, 2'd3, 1'b0});
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].req, vecs[i].note, vecs[i].dur, vecs[i].g, vecs[i].half, vecs[i].play);

    // Withdrawn request: dropped before the sampling edge, never acked.
    req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    begin
      int bad = 0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (ack !== 3'b000 || busy !== 1'b0) bad++;
      end
      chk("withdraw", bad, 0);
      $display("txn withdraw req=010");
    end

    // Reset mid-note: immediate abort, no done afterwards, then a fresh grant.
    req = 3'b001;
    note_in = 12'h006;
    dur_in = 24'h000003;
    step();
    chk("rst_pre_ack", {29'd0, ack}, 1);
    req = 3'b000;
    repeat (70) step();
    chk("rst_pre_piezo", {31'd0, piezo}, 1);
    rst = 1'b1;
    #1;
    chk("rst_async", {24'd0, ack, done, busy, owner, piezo}, {24'd0, 3'b0, 3'b0, 1'b0, 2'd3, 1'b0});
    step();
    chk("rst_next", {24'd0, ack, done, busy, owner, piezo}, {24'd0, 3'b0, 3'b0, 1'b0, 2'd3, 1'b0});
    rst = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k < 200; k++) begin
        step();
        if (done !== 3'b000 || busy !== 1'b0 || piezo !== 1'b0) bad++;
      end
      chk("rst_no_done", bad, 0);
      $display("txn reset mid-note");
    end
    do_txn(3'b001, 12'h006, 24'h000001, 0, 22, 50);

    for (int t = 0; t < 15; t++) begin
      logic [2:0]  r;
      logic [11:0] n;
      logic [23:0] d;
      int g;
      int de;
      r = 3'($urandom_range(1, 7));
      n = 12'($urandom);
      d = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
      g = r[2] ? 2 : (r[1] ? 1 : 0);
      de = int'(d[8*g +: 8]);
      if (de == 0) de = 1;
      do_txn(r, n, d, g, model_half(int'(n[4*g +: 4])), de * TD);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
